// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch unit: default geometry,
// the program-counter type and the next-PC source selector.
package fetch_pkg;

    localparam int DEF_PC_W      = 10;
    localparam int DEF_RAS_DEPTH = 4;
    localparam int DEF_PROG_CNT  = 3;

    typedef logic [DEF_PC_W-1:0] pc_t;

    typedef enum logic [2:0] {
        NPC_HOLD = 3'd0,
        NPC_BASE = 3'd1,
        NPC_INC  = 3'd2,
        NPC_ABS  = 3'd3,
        NPC_REL  = 3'd4,
        NPC_RET  = 3'd5
    } next_pc_sel_e;

endpackage

// File: rtl/ret_addr_stack.sv
// Return-address LIFO. Push and pop are ignored when they would overflow or
// underflow; the owner decides what that means. Clear empties the stack and
// takes priority over push/pop. Only the occupancy is reset; entry contents
// are don't-care until written.
module ret_addr_stack #(
    parameter int W     = 10,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [W-1:0]     i_data,
    output logic [W-1:0]     o_top,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     r_mem [2**IDX_W];
    logic [CNT_W-1:0] r_count;
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_top_idx;
    logic [CNT_W-1:0] w_top_cnt;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_count   = r_count;
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full && !i_clear;
    assign w_do_pop  = i_pop && !o_empty && !i_clear;
    assign w_wr_idx  = r_count[IDX_W-1:0];
    assign w_top_cnt = r_count - CNT_W'(1);
    assign w_top_idx = w_top_cnt[IDX_W-1:0];
    assign o_top     = r_mem[w_top_idx];

    // Occupancy counter: clear wins, then a single push or pop per cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (w_do_push) begin
            r_count <= r_count + CNT_W'(1);
        end else if (w_do_pop) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    // Entry storage: write the slot just above the current top on push.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= i_data;
        end
    end

endmodule

// File: rtl/inst_fetch_ras.sv
// Program counter / instruction fetch with selectable entry points,
// absolute and signed PC-relative branches, call/return stack, sticky
// Done on Halt, and a full-state Stall. ProgCtr addresses the ROM directly.
module inst_fetch_ras
    import fetch_pkg::*;
#(
    parameter int                PC_W      = DEF_PC_W,
    parameter int                RAS_DEPTH = DEF_RAS_DEPTH,
    parameter int                PROG_CNT  = DEF_PROG_CNT,
    parameter logic [PC_W-1:0]   PROG_BASE [PROG_CNT] = '{default: '0},
    parameter int                SEL_W     = (PROG_CNT > 1) ? $clog2(PROG_CNT) : 1,
    parameter int                CNT_W     = $clog2(RAS_DEPTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [SEL_W-1:0] ProgSel,
    input  logic             Stall,
    input  logic             Halt,
    input  logic             BranchAbs,
    input  logic             BranchRelEn,
    input  logic             ALU_flag,
    input  logic [PC_W-1:0]  Target,
    input  logic [PC_W-1:0]  Offset,
    input  logic             Call,
    input  logic             Ret,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Done,
    output logic [CNT_W-1:0] RasCount,
    output logic             RasOvf,
    output logic             RasUnf
);

    logic [PC_W-1:0] r_pc;
    logic            r_done;
    logic            r_ovf;
    logic            r_unf;

    next_pc_sel_e    w_sel;
    logic [PC_W-1:0] w_pc_next;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_base;
    logic [PC_W-1:0] w_ras_top;
    logic            w_ras_full;
    logic            w_ras_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_clear;
    logic            w_set_done;
    logic            w_set_ovf;
    logic            w_set_unf;

    assign w_pc_inc = r_pc + PC_W'(1);

    ret_addr_stack #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH),
        .CNT_W (CNT_W)
    ) u_ras (
        .i_clk   (Clk),
        .i_rst   (Reset),
        .i_clear (w_clear),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_pc_inc),
        .o_top   (w_ras_top),
        .o_count (RasCount),
        .o_full  (w_ras_full),
        .o_empty (w_ras_empty)
    );

    // Decide this cycle's action in strict priority order.
    always_comb begin
        w_sel      = NPC_INC;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_clear    = 1'b0;
        w_set_done = 1'b0;
        w_set_ovf  = 1'b0;
        w_set_unf  = 1'b0;
        if (Start) begin
            w_sel   = NPC_BASE;
            w_clear = 1'b1;
        end else if (Stall || r_done) begin
            w_sel = NPC_HOLD;
        end else if (Halt) begin
            w_sel      = NPC_HOLD;
            w_set_done = 1'b1;
        end else if (Ret) begin
            if (!w_ras_empty) begin
                w_sel = NPC_RET;
                w_pop = 1'b1;
            end else begin
                w_sel     = NPC_INC;
                w_set_unf = 1'b1;
            end
        end else if (Call) begin
            w_sel = NPC_ABS;
            if (!w_ras_full) begin
                w_push = 1'b1;
            end else begin
                w_set_ovf = 1'b1;
            end
        end else if (BranchAbs) begin
            w_sel = NPC_ABS;
        end else if (BranchRelEn && ALU_flag) begin
            w_sel = NPC_REL;
        end
    end

    // Entry-point lookup; an out-of-range selector falls back to entry 0.
    always_comb begin
        w_base = PROG_BASE[0];
        for (int i = 0; i < PROG_CNT; i++) begin
            if (int'(ProgSel) == i) begin
                w_base = PROG_BASE[i];
            end
        end
    end

    // Next-PC mux; relative add wraps naturally at PC_W bits.
    always_comb begin
        w_pc_next = r_pc;
        case (w_sel)
            NPC_HOLD: w_pc_next = r_pc;
            NPC_BASE: w_pc_next = w_base;
            NPC_INC:  w_pc_next = w_pc_inc;
            NPC_ABS:  w_pc_next = Target;
            NPC_REL:  w_pc_next = r_pc + Offset;
            NPC_RET:  w_pc_next = w_ras_top;
            default:  w_pc_next = r_pc;
        endcase
    end

    // PC and sticky status flags; Start clears the flags, others only set them.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_pc   <= '0;
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
        end else begin
            r_pc <= w_pc_next;
            if (Start) begin
                r_done <= 1'b0;
                r_ovf  <= 1'b0;
                r_unf  <= 1'b0;
            end else begin
                if (w_set_done) r_done <= 1'b1;
                if (w_set_ovf)  r_ovf  <= 1'b1;
                if (w_set_unf)  r_unf  <= 1'b1;
            end
        end
    end

    assign ProgCtr = r_pc;
    assign Done    = r_done;
    assign RasOvf  = r_ovf;
    assign RasUnf  = r_unf;

endmodule
